// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM states, lane helpers.
// Pure package: no logic, no latency.
// No flow control here; consumers own all handshakes.
package lsu_pkg;

  // Access-size encodings as carried on req_size.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;  // illegal encoding

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_STORE     = 3'd1,
    ST_LOAD_REQ  = 3'd2,
    ST_LOAD_WAIT = 3'd3,
    ST_RESP      = 3'd4
  } state_t;

  // Number of byte lanes touched by an access of the given size.
  function automatic logic [2:0] lane_count(input logic [1:0] size);
    case (size)
      SZ_B:    lane_count = 3'd1;
      SZ_H:    lane_count = 3'd2;
      default: lane_count = 3'd4;
    endcase
  endfunction

  // True when the byte offset does not suit the size, or the size is illegal.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = offset[0];
      SZ_W:    misaligned = (offset != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the addressed lane(s) of a memory word and sign/zero-extends.
// Latency: purely combinational.
// No backpressure; result follows inputs.
// Ports: r_data (memory word), offset (byte offset), size (SZ_*), is_unsigned, result (32-bit).
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] r_data,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = r_data[{offset, 3'b000} +: 8];
    // Halves are lane-aligned, so only offset[1] selects.
    half_v = offset[1] ? r_data[31:16] : r_data[15:0];
    case (size)
      SZ_B:    result = {{24{~is_unsigned & byte_v[7]}}, byte_v};
      SZ_H:    result = {{16{~is_unsigned & half_v[15]}}, half_v};
      default: result = r_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator for data_mem: one request at a time, stores split into single-lane beats.
// Latency: store resp N+1 cycles after accept (N = lanes), load resp 3 cycles after accept.
// Backpressure: req_ready only in IDLE; responses cannot be stalled.
// Ports: req_* (CPU request), resp_* (one-cycle completion), wren/is_load/mask_buffer/r_addr/
//        w_addr/w_data/r_data (data_mem side). Optional macro MISALIGN_TRAP_EN: misaligned or
//        illegal requests answer immediately with resp_err=1 and no memory beat; without it
//        the address is forced to size alignment, size 11 is a word, and resp_err is absent.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
`ifdef MISALIGN_TRAP_EN
  output logic              resp_err,
`endif
  output logic              wren,
  output logic              is_load,
  output logic [3:0]        mask_buffer,
  output logic [ADDR_W-1:0] r_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  input  logic [DATA_W-1:0] r_data
);

  state_t              state_q, state_d;
  logic [1:0]          size_q;
  logic                unsigned_q;
  logic [1:0]          off_q;
  logic [ADDR_W-1:0]   widx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [1:0]          beat_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   align_out;
  logic [1:0]          lane;
  logic                accept;
  logic [1:0]          size_n;
  logic [1:0]          off_n;
  logic                bad_n;
`ifdef MISALIGN_TRAP_EN
  logic                err_q;
`endif

  assign accept    = req_valid && (state_q == ST_IDLE);
  assign req_ready = (state_q == ST_IDLE);
  assign lane      = off_q + beat_q;

  // Request normalisation applied at the accept edge.
  always_comb begin
`ifdef MISALIGN_TRAP_EN
    size_n = req_size;
    off_n  = req_addr[1:0];
    bad_n  = misaligned(req_size, req_addr[1:0]);
`else
    size_n = (req_size == SZ_X) ? SZ_W : req_size;
    bad_n  = 1'b0;
    case (size_n)
      SZ_B:    off_n = req_addr[1:0];
      SZ_H:    off_n = {req_addr[1], 1'b0};
      default: off_n = 2'b00;
    endcase
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bad_n)             state_d = ST_RESP;
          else if (req_is_store) state_d = ST_STORE;
          else                   state_d = ST_LOAD_REQ;
        end
      end
      ST_STORE: begin
        if ({1'b0, beat_q} == lane_count(size_q) - 3'd1) state_d = ST_RESP;
      end
      ST_LOAD_REQ:  state_d = ST_LOAD_WAIT;
      ST_LOAD_WAIT: state_d = ST_RESP;
      ST_RESP:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  load_align u_load_align (
    .r_data      (r_data),
    .offset      (off_q),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .result      (align_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      size_q     <= SZ_B;
      unsigned_q <= 1'b0;
      off_q      <= 2'b00;
      widx_q     <= '0;
      wdata_q    <= '0;
      beat_q     <= 2'b00;
      rdata_q    <= '0;
`ifdef MISALIGN_TRAP_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        size_q     <= size_n;
        unsigned_q <= req_unsigned;
        off_q      <= off_n;
        widx_q     <= req_addr[ADDR_W+1:2];
        wdata_q    <= req_wdata;
        beat_q     <= 2'b00;
        // Cleared here so stores and trapped requests answer with zero data.
        rdata_q    <= '0;
`ifdef MISALIGN_TRAP_EN
        err_q      <= bad_n;
`endif
      end
      if (state_q == ST_STORE)     beat_q  <= beat_q + 2'd1;
      if (state_q == ST_LOAD_WAIT) rdata_q <= align_out;
    end
  end

  // Memory and response outputs are driven only in their own state, zero otherwise.
  always_comb begin
    wren        = 1'b0;
    is_load     = 1'b0;
    mask_buffer = 4'b0000;
    r_addr      = '0;
    w_addr      = '0;
    w_data      = '0;
    resp_valid  = 1'b0;
    resp_rdata  = '0;
`ifdef MISALIGN_TRAP_EN
    resp_err    = 1'b0;
`endif
    case (state_q)
      ST_STORE: begin
        wren        = 1'b1;
        mask_buffer = 4'b0001 << lane;
        w_addr      = widx_q;
        // Byte k of the store data lands in lane offset+k.
        w_data      = {{(DATA_W-8){1'b0}}, wdata_q[{beat_q, 3'b000} +: 8]} << {lane, 3'b000};
      end
      ST_LOAD_REQ: begin
        is_load = 1'b1;
        r_addr  = widx_q;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
`ifdef MISALIGN_TRAP_EN
        resp_err   = err_q;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: store beats, load extension, alignment, mid-op reset.
// Each request is followed for seven cycles with per-cycle logs checked against hand values.
// Memory read data is returned one cycle after is_load.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        wren;
  logic        is_load;
  logic [3:0]  mask_buffer;
  logic [4:0]  r_addr;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic [31:0] r_data;
  logic [31:0] load_value;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  log_wren, log_isload, log_resp, log_err;
  logic [3:0]  log_mask  [8];
  logic [31:0] log_wdata [8];
  logic [4:0]  log_waddr [8];
  logic [4:0]  log_raddr [8];
  logic [31:0] log_rdata [8];

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
`ifdef MISALIGN_TRAP_EN
    .resp_err     (resp_err),
`endif
    .wren         (wren),
    .is_load      (is_load),
    .mask_buffer  (mask_buffer),
    .r_addr       (r_addr),
    .w_addr       (w_addr),
    .w_data       (w_data),
    .r_data       (r_data)
  );

`ifndef MISALIGN_TRAP_EN
  assign resp_err = 1'b0;
`endif

  // Memory model: read word appears the cycle after the read strobe, zero otherwise.
  always @(posedge clk) begin
    if (rst) r_data <= 32'h0;
    else     r_data <= is_load ? load_value : 32'h0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request, then log cycles 1..7 after the accept edge.
  task automatic run_op(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] mv);
    logic viol;
    @(negedge clk);
    check("ready_before_req", {31'b0, req_ready}, 32'd1);
    load_value   = mv;
    req_valid    = 1'b1;
    req_is_store = st;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    @(posedge clk);
    #1;
    // Garbage on the request bus must not disturb the registered request.
    req_valid = 1'b0;
    req_size  = 2'b11;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'hFFFF_FFFF;
    log_wren = '0; log_isload = '0; log_resp = '0; log_err = '0;
    viol = 1'b0;
    for (int k = 1; k < 8; k++) begin
      log_wren[k]   = wren;
      log_isload[k] = is_load;
      log_resp[k]   = resp_valid;
      log_err[k]    = resp_err;
      log_mask[k]   = mask_buffer;
      log_wdata[k]  = w_data;
      log_waddr[k]  = w_addr;
      log_raddr[k]  = r_addr;
      log_rdata[k]  = resp_rdata;
      if (wren && is_load) viol = 1'b1;
      if (!wren && (mask_buffer != 4'h0 || w_addr != 5'd0 || w_data != 32'h0)) viol = 1'b1;
      if (!is_load && r_addr != 5'd0) viol = 1'b1;
      if (!resp_valid && (resp_rdata != 32'h0 || resp_err)) viol = 1'b1;
      if (k > 1 && k < 4 && req_ready && (log_wren[k] || log_isload[k])) viol = 1'b1;
      if (k < 7) begin
        @(posedge clk);
        #1;
      end
    end
    check("outputs_zero_outside_beat", {31'b0, viol}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; load_value = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready",   {31'b0, req_ready},   32'd1);
    check("rst_wren",        {31'b0, wren},        32'd0);
    check("rst_is_load",     {31'b0, is_load},     32'd0);
    check("rst_resp_valid",  {31'b0, resp_valid},  32'd0);
    check("rst_mask",        {28'b0, mask_buffer}, 32'd0);
    check("rst_resp_rdata",  resp_rdata,           32'd0);
    rst = 1'b0;

    // SW 0xA1B2C3D4 @0x08
    run_op(1'b1, 2'b10, 1'b0, 32'h08, 32'hA1B2C3D4, 32'h0);
    check("sw_wren_cycles",  {24'b0, log_wren},   32'h1E);
    check("sw_resp_cycle",   {24'b0, log_resp},   32'h20);
    check("sw_no_isload",    {24'b0, log_isload}, 32'h00);
    check("sw_waddr",        {27'b0, log_waddr[1]}, 32'd2);
    check("sw_mask1",        {28'b0, log_mask[1]}, 32'h1);
    check("sw_mask2",        {28'b0, log_mask[2]}, 32'h2);
    check("sw_mask3",        {28'b0, log_mask[3]}, 32'h4);
    check("sw_mask4",        {28'b0, log_mask[4]}, 32'h8);
    check("sw_wdata1",       log_wdata[1], 32'h000000D4);
    check("sw_wdata2",       log_wdata[2], 32'h0000C300);
    check("sw_wdata3",       log_wdata[3], 32'h00B20000);
    check("sw_wdata4",       log_wdata[4], 32'hA1000000);
    check("sw_rdata_zero",   log_rdata[5], 32'h0);

    // SB 0x55 @0x13
    run_op(1'b1, 2'b00, 1'b0, 32'h13, 32'h00000055, 32'h0);
    check("sb_wren_cycles",  {24'b0, log_wren}, 32'h02);
    check("sb_resp_cycle",   {24'b0, log_resp}, 32'h04);
    check("sb_waddr",        {27'b0, log_waddr[1]}, 32'd4);
    check("sb_mask",         {28'b0, log_mask[1]}, 32'h8);
    check("sb_wdata",        log_wdata[1], 32'h55000000);

    // SH 0xBEEF @0xCA: upper half, address bits above the memory wrap
    run_op(1'b1, 2'b01, 1'b0, 32'hCA, 32'h1234BEEF, 32'h0);
    check("sh_wren_cycles",  {24'b0, log_wren}, 32'h06);
    check("sh_resp_cycle",   {24'b0, log_resp}, 32'h08);
    check("sh_waddr_wrap",   {27'b0, log_waddr[1]}, 32'd18);
    check("sh_mask1",        {28'b0, log_mask[1]}, 32'h4);
    check("sh_mask2",        {28'b0, log_mask[2]}, 32'h8);
    check("sh_wdata1",       log_wdata[1], 32'h00EF0000);
    check("sh_wdata2",       log_wdata[2], 32'hBE000000);

    // LB signed / LBU @0x05
    run_op(1'b0, 2'b00, 1'b0, 32'h05, 32'h0, 32'h0000800F);
    check("lb_isload_cycles", {24'b0, log_isload}, 32'h02);
    check("lb_no_wren",       {24'b0, log_wren},   32'h00);
    check("lb_raddr",         {27'b0, log_raddr[1]}, 32'd1);
    check("lb_resp_cycle",    {24'b0, log_resp},   32'h08);
    check("lb_rdata",         log_rdata[3], 32'hFFFFFF80);
    run_op(1'b0, 2'b00, 1'b1, 32'h05, 32'h0, 32'h0000800F);
    check("lbu_rdata",        log_rdata[3], 32'h00000080);

    // LH signed @0x02, LW @0x1C
    run_op(1'b0, 2'b01, 1'b0, 32'h02, 32'h0, 32'h9ABC1234);
    check("lh_rdata",         log_rdata[3], 32'hFFFF9ABC);
    run_op(1'b0, 2'b10, 1'b0, 32'h1C, 32'h0, 32'h9ABC1234);
    check("lw_raddr",         {27'b0, log_raddr[1]}, 32'd7);
    check("lw_rdata",         log_rdata[3], 32'h9ABC1234);

    // LW @0x06 (misaligned)
    run_op(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'hDEADBEEF);
`ifdef MISALIGN_TRAP_EN
    check("lw_mis_resp_cycle", {24'b0, log_resp},   32'h02);
    check("lw_mis_err",        {24'b0, log_err},    32'h02);
    check("lw_mis_no_isload",  {24'b0, log_isload}, 32'h00);
    check("lw_mis_no_wren",    {24'b0, log_wren},   32'h00);
    check("lw_mis_rdata",      log_rdata[1], 32'h0);
`else
    check("lw_mis_raddr",      {27'b0, log_raddr[1]}, 32'd1);
    check("lw_mis_isload",     {24'b0, log_isload}, 32'h02);
    check("lw_mis_resp_cycle", {24'b0, log_resp},   32'h08);
    check("lw_mis_rdata",      log_rdata[3], 32'hDEADBEEF);
`endif

    // Reset during beat 2 of a word store
    begin
      int wren_after, resp_after;
      @(negedge clk);
      req_valid = 1'b1; req_is_store = 1'b1; req_size = 2'b10;
      req_addr = 32'h08; req_wdata = 32'h11223344;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      check("rst_mid_beat2_wren", {31'b0, wren}, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      wren_after = 0; resp_after = 0;
      for (int k = 0; k < 6; k++) begin
        if (wren) wren_after++;
        if (resp_valid) resp_after++;
        @(posedge clk);
        #1;
      end
      check("rst_mid_no_wren",  wren_after, 32'd0);
      check("rst_mid_no_resp",  resp_after, 32'd0);
      check("rst_mid_ready",    {31'b0, req_ready}, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
